// File: rtl/demux8_router.sv
// demux8_router: routes a tagged DW-bit stream to eight one-entry output slots, with unicast or broadcast delivery.
// Optional per-channel delivered-word counters are enabled with `define DEMUX_COUNT_EN.
module demux8_router #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [2:0]      in_sel,
  input  logic            in_bcast,
  output logic [7:0]      out_valid,
  input  logic [7:0]      out_ready,
  output logic [8*DW-1:0] out_data
`ifdef DEMUX_COUNT_EN
  ,
  input  logic [2:0]      cnt_sel,
  output logic [7:0]      cnt_val
`endif
);

  logic [7:0] can_load;
  logic [7:0] load;
  logic       accept;

  // A slot may take a new word when it is empty or being drained this cycle.
  always_comb begin
    can_load = ~out_valid | out_ready;
    in_ready = in_bcast ? (&can_load) : can_load[in_sel];
    accept   = in_valid && in_ready;
    load     = '0;
    for (int k = 0; k < 8; k++) begin
      load[k] = accept && (in_bcast || (in_sel == 3'(k)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (load[k]) begin
          out_valid[k]          <= 1'b1;
          out_data[k*DW +: DW]  <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k]          <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [7:0] cnt [8];

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (load[k]) cnt[k] <= cnt[k] + 8'd1;
      end
    end
  end

  assign cnt_val = cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_demux8_router.sv
// tb_demux8_router: directed self-checking bench for demux8_router.
// Counter checks are compiled in only when DEMUX_COUNT_EN is defined.
module tb_demux8_router;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
`ifdef DEMUX_COUNT_EN
  logic [2:0]  cnt_sel;
  logic [7:0]  cnt_val;
`endif

  int checks;
  int failures;

  demux8_router #(.DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_val   (cnt_val)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] s,
                               input logic b, input logic [7:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
`ifdef DEMUX_COUNT_EN
    cnt_sel  = 3'd0;
`endif
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    checkOutput("reset_valid", 64'(out_valid), 64'h00);
    checkOutput("reset_ready", 64'(in_ready), 64'h1);
    checkOutput("reset_data", out_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Unicast to channel 5, then drain.
    applyStimulus(1'b1, 8'hA5, 3'd5, 1'b0, 8'h00);
    checkOutput("uni_ready", 64'(in_ready), 64'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h20);
    checkOutput("uni_valid", 64'(out_valid), 64'h20);
    checkOutput("uni_data", 64'(out_data[47:40]), 64'hA5);
    tick();
    checkOutput("uni_drain", 64'(out_valid), 64'h00);

    // Backpressure on channel 2 with same-cycle drain and reload.
    applyStimulus(1'b1, 8'h11, 3'd2, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 8'h22, 3'd2, 1'b0, 8'h00);
    checkOutput("bp_ready_low", 64'(in_ready), 64'h0);
    tick();
    checkOutput("bp_hold_valid", 64'(out_valid), 64'h04);
    checkOutput("bp_hold_data", 64'(out_data[23:16]), 64'h11);
    applyStimulus(1'b1, 8'h22, 3'd2, 1'b0, 8'h04);
    checkOutput("bp_ready_high", 64'(in_ready), 64'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h04);
    checkOutput("bp_reload_valid", 64'(out_valid), 64'h04);
    checkOutput("bp_reload_data", 64'(out_data[23:16]), 64'h22);
    tick();
    checkOutput("bp_drain", 64'(out_valid), 64'h00);

    // Channel 3 stalled and full must not block channel 6.
    applyStimulus(1'b1, 8'h33, 3'd3, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 8'h66, 3'd6, 1'b0, 8'h00);
    checkOutput("ind_ready", 64'(in_ready), 64'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    checkOutput("ind_valid", 64'(out_valid), 64'h48);
    checkOutput("ind_ch6", 64'(out_data[55:48]), 64'h66);
    checkOutput("ind_ch3", 64'(out_data[31:24]), 64'h33);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
    tick();
    checkOutput("ind_drain", 64'(out_valid), 64'h00);

    // Broadcast waits for stalled channel 0, then loads all slots at once.
    applyStimulus(1'b1, 8'h0F, 3'd0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 8'h3C, 3'd4, 1'b1, 8'h00);
    checkOutput("bc_ready_low", 64'(in_ready), 64'h0);
    tick();
    checkOutput("bc_hold_valid", 64'(out_valid), 64'h01);
    checkOutput("bc_hold_data", 64'(out_data[7:0]), 64'h0F);
    applyStimulus(1'b1, 8'h3C, 3'd4, 1'b1, 8'h01);
    checkOutput("bc_ready_high", 64'(in_ready), 64'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    checkOutput("bc_valid", 64'(out_valid), 64'hFF);
    checkOutput("bc_data", out_data, 64'h3C3C3C3C3C3C3C3C);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
    tick();
    checkOutput("bc_drain", 64'(out_valid), 64'h00);

    // Asynchronous reset discards a held word immediately.
    applyStimulus(1'b1, 8'h44, 3'd4, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    checkOutput("mid_loaded", 64'(out_valid), 64'h10);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'h00);
    checkOutput("mid_rst_data", out_data, 64'h0);
    rst_n = 1'b1;
    tick();

`ifdef DEMUX_COUNT_EN
    // 257 words to channel 1 wrap its counter to 1; a broadcast adds one everywhere.
    cnt_sel = 3'd1;
    #1;
    checkOutput("cnt_reset", 64'(cnt_val), 64'h00);
    applyStimulus(1'b1, 8'h77, 3'd1, 1'b0, 8'hFF);
    for (int i = 0; i < 257; i++) tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
    checkOutput("cnt_wrap", 64'(cnt_val), 64'h01);
    applyStimulus(1'b1, 8'h5A, 3'd0, 1'b1, 8'hFF);
    tick();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
    checkOutput("cnt_bc_ch1", 64'(cnt_val), 64'h02);
    cnt_sel = 3'd0;
    #1;
    checkOutput("cnt_bc_ch0", 64'(cnt_val), 64'h01);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
